pc_sequencer: RTL

Program-counter sequencer for the single-cycle core. It consumes the branch lookup table: the sequencer drives the table's enable and key, receives the 12-bit absolute target, and advances or redirects the PC. It owns the run/halt lifecycle and keeps saturating cycle and taken-branch counters for the test harness. It sits between the decoder (branch/halt/stall requests) and instruction memory (PC address).

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_sequencer_sat_counter.sv | 35 +++
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencer and its helpers:
//   seq_state_t    - run/halt lifecycle states
//   *_W_DEFAULT    - default widths for PC, branch key and counters
//   NO_TARGET      - LUT return value that marks an unmapped branch key
// ---------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int PC_W_DEFAULT  = 12;
    localparam int KEY_W_DEFAULT = 5;
    localparam int CNT_W_DEFAULT = 16;

    // The branch LUT returns this target for keys it does not map.
    localparam int NO_TARGET = 0;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high clear
//   clear  - synchronous clear; wins over inc
//   inc    - count one event this cycle
//   count  - current value
// ---------------------------------------------------------------------------
module sat_counter
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the single-cycle core. Drives the external
// branch LUT, advances or redirects the PC, owns the IDLE/RUN/DONE lifecycle
// and keeps saturating cycle and taken-branch counters.
// Ports:
//   clk, reset         - clock; asynchronous active-high reset
//   start              - begin execution at START_PC (ignored while running)
//   stall              - hold the PC this cycle
//   branch_en          - current instruction is a branch
//   branch_taken       - branch condition is true
//   branch_key         - key of the current branch
//   halt_req           - current instruction is a halt
//   branch_pos         - combinational target returned by the LUT
//   branch_lut_en      - LUT enable (combinational)
//   lut_key            - key forwarded to the LUT (combinational, 0 when idle)
//   pc                 - current instruction address
//   running, done      - lifecycle status
//   bad_key            - sticky: a taken branch resolved to NO_TARGET
//   cycle_count        - RUN cycles, saturating
//   branch_count       - redirecting taken branches, saturating
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int KEY_W    = KEY_W_DEFAULT,
    parameter int START_PC = 0,
    parameter int MAX_PC   = 4095,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             branch_taken,
    input  logic [KEY_W-1:0] branch_key,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  branch_pos,
    output logic             branch_lut_en,
    output logic [KEY_W-1:0] lut_key,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic             bad_key,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] branch_count
);

    localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);
    localparam logic [PC_W-1:0] LAST_ADDR  = PC_W'(MAX_PC);
    localparam logic [PC_W-1:0] UNMAPPED   = PC_W'(NO_TARGET);

    seq_state_t state;
    seq_state_t state_next;

    logic launch;    // start accepted from IDLE or DONE
    logic advance;   // RUN cycle that is neither halted nor stalled
    logic redirect;  // taken branch with a mapped target
    logic unmapped;  // taken branch whose key the LUT does not know
    logic at_end;    // fall-through from the last legal address

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE, DONE: if (start)             state_next = RUN;
            RUN:        if (halt_req || at_end) state_next = DONE;
            default:                            state_next = IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        launch        = (state != RUN) && start;
        // halt and stall both suppress the lookup, so halt's precedence
        // over branch falls out of the enable itself.
        branch_lut_en = (state == RUN) && branch_en && branch_taken
                        && !stall && !halt_req;
        lut_key       = branch_lut_en ? branch_key : '0;
        advance       = (state == RUN) && !halt_req && !stall;
        redirect      = branch_lut_en && (branch_pos != UNMAPPED);
        unmapped      = branch_lut_en && (branch_pos == UNMAPPED);
        // An unmapped taken branch is a fall-through, so it can end the run too.
        at_end        = advance && !redirect && (pc == LAST_ADDR);
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

    // ---------------- PC and sticky flag ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= START_ADDR;
            bad_key <= 1'b0;
        end else begin
            if (launch) begin
                pc <= START_ADDR;
            end else if (redirect) begin
                pc <= branch_pos;
            end else if (advance && !at_end) begin
                pc <= pc + 1'b1;
            end

            if (launch) begin
                bad_key <= 1'b0;
            end else if (unmapped) begin
                bad_key <= 1'b1;
            end
        end
    end

    // ---------------- counters ----------------
    sat_counter #(.WIDTH(CNT_W)) u_cycle_count (
        .clk   (clk),
        .reset (reset),
        .clear (launch),
        .inc   (state == RUN),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_branch_count (
        .clk   (clk),
        .reset (reset),
        .clear (launch),
        .inc   (redirect),
        .count (branch_count)
    );

endmodule
